// File: rtl/bdi_comp_scheduler.sv
// Round-robin two-requester sequencer feeding the BDI compressor and holding its result.
// Optional counters on out handshakes and raw-encoded lines are enabled by BDI_SCHED_STATS_EN.
module bdi_comp_scheduler #(
    parameter int LINE_W   = 256,
    parameter int TAG_W    = 16,
    parameter int COMP_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [LINE_W-1:0] r0_line,
    input  logic [TAG_W-1:0]  r0_tag,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [LINE_W-1:0] r1_line,
    input  logic [TAG_W-1:0]  r1_tag,
    output logic              cmp_start,
    output logic [LINE_W-1:0] cmp_line,
    input  logic [LINE_W-1:0] cmp_data,
    input  logic [3:0]        cmp_enc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_data,
    output logic [3:0]        out_enc,
    output logic              out_src,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
`ifdef BDI_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_lines,
    output logic [15:0]       stat_raw
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(COMP_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_rr_ptr;
    logic [3:0]        r_cnt;
    logic [LINE_W-1:0] r_cmp_line;
    logic [LINE_W-1:0] r_out_data;
    logic [3:0]        r_out_enc;
    logic              r_out_src;
    logic [TAG_W-1:0]  r_out_tag;

    logic              w_gnt_r0;
    logic              w_gnt_r1;
    logic              w_accept;
    logic              w_out_hs;

    // A lone requester always wins; on contention the round-robin pointer decides.
    assign w_gnt_r0 = r0_valid & (~r1_valid | ~r_rr_ptr);
    assign w_gnt_r1 = r1_valid & (~r0_valid |  r_rr_ptr);
    assign w_accept = (r_state == S_IDLE) & (r0_valid | r1_valid);
    assign w_out_hs = (r_state == S_OUT) & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next = S_ISSUE;
            S_ISSUE:                 w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_OUT;
            S_OUT:   if (out_ready)  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_comb begin
        r0_ready  = (r_state == S_IDLE) & w_gnt_r0;
        r1_ready  = (r_state == S_IDLE) & w_gnt_r1;
        cmp_start = (r_state == S_ISSUE);
        out_valid = (r_state == S_OUT);
        busy      = (r_state != S_IDLE);
    end

    // Request/result registers; the compressed line is sampled on the last WAIT cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= 1'b0;
            r_cnt      <= 4'd0;
            r_cmp_line <= '0;
            r_out_data <= '0;
            r_out_enc  <= 4'd0;
            r_out_src  <= 1'b0;
            r_out_tag  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmp_line <= w_gnt_r1 ? r1_line : r0_line;
                        r_out_tag  <= w_gnt_r1 ? r1_tag  : r0_tag;
                        r_out_src  <= w_gnt_r1;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= LAT_M1;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_out_data <= cmp_data;
                        r_out_enc  <= cmp_enc;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_rr_ptr <= ~r_out_src;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmp_line = r_cmp_line;
    assign out_data = r_out_data;
    assign out_enc  = r_out_enc;
    assign out_src  = r_out_src;
    assign out_tag  = r_out_tag;

`ifdef BDI_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_stat_lines;
    logic [15:0] r_stat_raw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_lines <= 16'd0;
            r_stat_raw   <= 16'd0;
        end else if (w_out_hs) begin
            r_stat_lines <= sat_inc(r_stat_lines);
            if (r_out_enc == 4'hF) begin
                r_stat_raw <= sat_inc(r_stat_raw);
            end
        end
    end

    assign stat_lines = r_stat_lines;
    assign stat_raw   = r_stat_raw;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_out_hs;
`endif

endmodule

// File: tb/tb_bdi_comp_scheduler.sv
// Randomized and directed bench for bdi_comp_scheduler against a cycle-count transaction model.
module tb_bdi_comp_scheduler;

    localparam int LW    = 256;
    localparam int TW    = 16;
    localparam int LAT   = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 15;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic          r0_valid, r1_valid, out_ready;
    logic [LW-1:0] r0_line, r1_line;
    logic [TW-1:0] r0_tag, r1_tag;
    logic          r0_ready, r1_ready, cmp_start, out_valid, out_src, busy;
    logic [LW-1:0] cmp_line, cmp_data, out_data;
    logic [3:0]    cmp_enc, out_enc;
    logic [TW-1:0] out_tag;
    logic          fix_en;
    logic [3:0]    fix_enc;

    logic          x_valid  [2];
    logic          x_ready  [2];
    logic          x_r1rdy  [2];
    logic          x_start  [2];
    logic          x_ov     [2];
    logic          x_src    [2];
    logic          x_busy   [2];
    logic [LW-1:0] x_line   [2];
    logic [LW-1:0] x_cdata  [2];
    logic [LW-1:0] x_odata  [2];
    logic [3:0]    x_cenc   [2];
    logic [3:0]    x_oenc   [2];
    logic [TW-1:0] x_tag    [2];
    logic          zero = 1'b0;
    logic          one  = 1'b1;
`ifdef BDI_SCHED_STATS_EN
    logic [15:0]   stat_lines, stat_raw;
    logic [15:0]   x_sl [2];
    logic [15:0]   x_sr [2];
`endif

    bdi_comp_scheduler #(.LINE_W(LW), .TAG_W(TW), .COMP_LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_line(r0_line), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_line(r1_line), .r1_tag(r1_tag),
        .cmp_start(cmp_start), .cmp_line(cmp_line), .cmp_data(cmp_data), .cmp_enc(cmp_enc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_enc(out_enc),
        .out_src(out_src), .out_tag(out_tag), .busy(busy)
`ifdef BDI_SCHED_STATS_EN
        , .stat_lines(stat_lines), .stat_raw(stat_raw)
`endif
    );

    bdi_comp_scheduler #(.LINE_W(LW), .TAG_W(TW), .COMP_LAT(LAT_A)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .r0_valid(x_valid[0]), .r0_ready(x_ready[0]), .r0_line(r0_line), .r0_tag(r0_tag),
        .r1_valid(zero), .r1_ready(x_r1rdy[0]), .r1_line(r1_line), .r1_tag(r1_tag),
        .cmp_start(x_start[0]), .cmp_line(x_line[0]), .cmp_data(x_cdata[0]), .cmp_enc(x_cenc[0]),
        .out_valid(x_ov[0]), .out_ready(one), .out_data(x_odata[0]), .out_enc(x_oenc[0]),
        .out_src(x_src[0]), .out_tag(x_tag[0]), .busy(x_busy[0])
`ifdef BDI_SCHED_STATS_EN
        , .stat_lines(x_sl[0]), .stat_raw(x_sr[0])
`endif
    );

    bdi_comp_scheduler #(.LINE_W(LW), .TAG_W(TW), .COMP_LAT(LAT_B)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .r0_valid(x_valid[1]), .r0_ready(x_ready[1]), .r0_line(r0_line), .r0_tag(r0_tag),
        .r1_valid(zero), .r1_ready(x_r1rdy[1]), .r1_line(r1_line), .r1_tag(r1_tag),
        .cmp_start(x_start[1]), .cmp_line(x_line[1]), .cmp_data(x_cdata[1]), .cmp_enc(x_cenc[1]),
        .out_valid(x_ov[1]), .out_ready(one), .out_data(x_odata[1]), .out_enc(x_oenc[1]),
        .out_src(x_src[1]), .out_tag(x_tag[1]), .busy(x_busy[1])
`ifdef BDI_SCHED_STATS_EN
        , .stat_lines(x_sl[1]), .stat_raw(x_sr[1])
`endif
    );

    // Compressor stand-in: correct result only in the cycle exactly LAT after cmp_start.
    function automatic logic [LW-1:0] fdata(input logic [LW-1:0] l);
        return {l[7:0], l[LW-1:8]} ^ {8{32'h5A5A_C3C3}};
    endfunction

    function automatic logic [3:0] fenc(input logic [LW-1:0] l, input logic fe, input logic [3:0] fv);
        return fe ? fv : (l[3:0] ^ l[11:8]);
    endfunction

    int c_main, cx0, cx1;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_main <= 0; cx0 <= 0; cx1 <= 0;
        end else begin
            c_main <= cmp_start  ? 1 : ((c_main != 0 && c_main < 64) ? c_main + 1 : c_main);
            cx0    <= x_start[0] ? 1 : ((cx0 != 0 && cx0 < 64) ? cx0 + 1 : cx0);
            cx1    <= x_start[1] ? 1 : ((cx1 != 0 && cx1 < 64) ? cx1 + 1 : cx1);
        end
    end

    assign cmp_data   = (c_main == LAT)  ? fdata(cmp_line)   : ~fdata(cmp_line);
    assign cmp_enc    = (c_main == LAT)  ? fenc(cmp_line, fix_en, fix_enc) : ~fenc(cmp_line, fix_en, fix_enc);
    assign x_cdata[0] = (cx0 == LAT_A)   ? fdata(x_line[0])  : ~fdata(x_line[0]);
    assign x_cenc[0]  = (cx0 == LAT_A)   ? fenc(x_line[0], 1'b0, 4'h0) : ~fenc(x_line[0], 1'b0, 4'h0);
    assign x_cdata[1] = (cx1 == LAT_B)   ? fdata(x_line[1])  : ~fdata(x_line[1]);
    assign x_cenc[1]  = (cx1 == LAT_B)   ? fenc(x_line[1], 1'b0, 4'h0) : ~fenc(x_line[1], 1'b0, 4'h0);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction model: one request in flight, result due 2+LAT cycles after acceptance.
    bit            m_busy, m_rr, m_src, keep;
    int            cyc, m_acc, m_ov, m_lines, m_raw;
    logic [LW-1:0] m_line, m_data;
    logic [3:0]    m_enc;
    logic [TW-1:0] m_tag;
    int            served[$];

    task automatic rand_line(output logic [LW-1:0] l);
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    endtask

    task automatic check_model();
        bit e0, e1, eov;
        e0  = !m_busy && r0_valid && (!r1_valid || !m_rr);
        e1  = !m_busy && r1_valid && (!r0_valid ||  m_rr);
        eov = m_busy && (cyc >= m_ov);
        chk1("r0_ready", r0_ready, e0);
        chk1("r1_ready", r1_ready, e1);
        chk1("busy", busy, m_busy);
        chk1("cmp_start", cmp_start, m_busy && (cyc == m_acc + 1));
        chk1("out_valid", out_valid, eov);
        if (m_busy) chkv("cmp_line", cmp_line, m_line);
        if (eov) begin
            chkv("out_data", out_data, m_data);
            chkv("out_enc", LW'(out_enc), LW'(m_enc));
            chkv("out_tag", LW'(out_tag), LW'(m_tag));
            chk1("out_src", out_src, m_src);
        end
        if (eov && out_ready) begin
            m_busy = 0;
            m_rr   = !m_src;
            served.push_back(int'(m_src));
            if (m_lines < 16'hFFFF) m_lines++;
            if (m_enc == 4'hF && m_raw < 16'hFFFF) m_raw++;
        end else if (e0 || e1) begin
            m_busy = 1;
            m_acc  = cyc;
            m_ov   = cyc + 2 + LAT;
            m_src  = e1;
            m_line = e1 ? r1_line : r0_line;
            m_tag  = e1 ? r1_tag  : r0_tag;
            m_data = fdata(m_line);
            m_enc  = fenc(m_line, fix_en, fix_enc);
        end
    endtask

    task automatic cyc_step(input bit v0, input bit v1, input bit ordy);
        @(posedge clock);
        #1;
        cyc++;
        if (!keep) begin
            rand_line(r0_line);
            rand_line(r1_line);
            r0_tag = 16'($urandom);
            r1_tag = 16'($urandom);
        end
        r0_valid  = v0;
        r1_valid  = v1;
        out_ready = ordy;
        @(negedge clock);
        check_model();
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, ".r0_ready"}, r0_ready, 1'b0);
        chk1({tag, ".r1_ready"}, r1_ready, 1'b0);
        chk1({tag, ".cmp_start"}, cmp_start, 1'b0);
        chk1({tag, ".out_valid"}, out_valid, 1'b0);
        chk1({tag, ".busy"}, busy, 1'b0);
        chk1({tag, ".out_src"}, out_src, 1'b0);
        chkv({tag, ".cmp_line"}, cmp_line, '0);
        chkv({tag, ".out_data"}, out_data, '0);
        chkv({tag, ".out_enc"}, LW'(out_enc), '0);
        chkv({tag, ".out_tag"}, LW'(out_tag), '0);
    endtask

    task automatic lat_check(input int k, input int lat);
        logic [LW-1:0] l;
        logic [TW-1:0] t;
        @(posedge clock);
        #1;
        rand_line(r0_line);
        r0_tag     = 16'($urandom);
        x_valid[k] = 1'b1;
        @(negedge clock);
        chk1("lat.ready", x_ready[k], 1'b1);
        l = r0_line;
        t = r0_tag;
        @(posedge clock);
        #1;
        x_valid[k] = 1'b0;
        for (int n = 1; n <= lat + 2; n++) begin
            if (n > 1) @(posedge clock);
            @(negedge clock);
            chk1("lat.cmp_start", x_start[k], n == 1);
            chkv("lat.cmp_line", x_line[k], l);
            chk1("lat.out_valid", x_ov[k], n == lat + 2);
            if (n == 1) rand_line(r0_line);
            if (n == lat + 2) begin
                chkv("lat.out_data", x_odata[k], fdata(l));
                chkv("lat.out_enc", LW'(x_oenc[k]), LW'(fenc(l, 1'b0, 4'h0)));
                chkv("lat.out_tag", LW'(x_tag[k]), LW'(t));
                chk1("lat.out_src", x_src[k], 1'b0);
            end
        end
        @(posedge clock);
        @(negedge clock);
        chk1("lat.idle_ov", x_ov[k], 1'b0);
        chk1("lat.idle_busy", x_busy[k], 1'b0);
        chk1("lat.r1_ready", x_r1rdy[k], 1'b0);
    endtask

    task automatic model_reset();
        m_busy = 0; m_rr = 0; m_lines = 0; m_raw = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] dl;
        r0_valid = 0; r1_valid = 0; out_ready = 0;
        r0_line = '0; r1_line = '0; r0_tag = '0; r1_tag = '0;
        x_valid[0] = 0; x_valid[1] = 0;
        fix_en = 0; fix_enc = 4'h0; keep = 0; cyc = 0;
        model_reset();

        // Reset state
        #1 reset_n = 1'b0;
        #2 chk_zero("reset");
        chk1("reset.lat1_ov", x_ov[0], 1'b0);
        #19 reset_n = 1'b1;

        // Both requesters valid out of reset: r0, r1, r0 alternation
        served.delete();
        for (int i = 0; i < 20; i++) cyc_step(1, 1, 1);
        chk1("alt.count", served.size() >= 3, 1'b1);
        if (served.size() >= 3) begin
            chkv("alt.first",  LW'(served[0]), LW'(0));
            chkv("alt.second", LW'(served[1]), LW'(1));
            chkv("alt.third",  LW'(served[2]), LW'(0));
        end
        for (int i = 0; i < 6; i++) cyc_step(0, 0, 1);

        // r0 only with a fixed line and encoding 2
        keep = 1; fix_en = 1; fix_enc = 4'h2;
        dl = {64'h66, 64'h44, 64'h22, 64'hFF};
        r0_line = dl; r0_tag = 16'h1234;
        cyc_step(1, 0, 1);
        for (int i = 0; i < 5; i++) cyc_step(0, 0, 1);
        keep = 0; fix_en = 0;

        // Stall in OUT for 5 cycles with both requesters pending
        cyc_step(1, 0, 1);
        for (int i = 0; i < 3; i++) cyc_step(0, 0, 0);
        for (int i = 0; i < 5; i++) cyc_step(1, 1, 0);
        cyc_step(0, 0, 1);
        cyc_step(0, 0, 0);

        // Reset while waiting on the compressor
        cyc_step(1, 0, 1);
        cyc_step(0, 0, 1);
        cyc_step(0, 0, 1);
        #2;
        r0_valid = 0; r1_valid = 0;
        reset_n = 1'b0;
        #1 chk_zero("midreset");
        model_reset();
        @(negedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc_step(0, 0, 1);
        cyc_step(0, 1, 1);
        for (int i = 0; i < 6; i++) cyc_step(0, 0, 1);

        // Randomized traffic with backpressure
        for (int i = 0; i < 400; i++)
            cyc_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 8; i++) cyc_step(0, 0, 1);

`ifdef BDI_SCHED_STATS_EN
        chkv("stat_lines", LW'(stat_lines), LW'(m_lines));
        chkv("stat_raw", LW'(stat_raw), LW'(m_raw));
`endif

        // Latency extremes
        lat_check(0, LAT_A);
        lat_check(1, LAT_B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
